friscv_axi_ram_slave: RTL and testbench

AXI4 responder that sits at the central-memory end of the cache memory controllers and serves their single-beat and INCR-burst requests from an internal RAM array. Read and write channels are independent. Reads are queued in an outstanding-request FIFO and returned in order. Writes apply per-byte WSTRB and return one BRESP per burst.

---
 rtl/friscv_axi_ram_slave_if.sv | 52 +++++
 rtl/friscv_axi_ram_slave.sv | 234 +++++++++++++++++++++++
 tb/tb_friscv_axi_ram_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/friscv_axi_ram_slave_if.sv
// AXI4 bundle between the cache memory controllers (master) and the RAM responder (slave).
interface friscv_axi_ram_slave_if #(
    parameter int AXI_ADDR_W = 16,
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 128
);
    logic                    slv_awvalid;
    logic                    slv_awready;
    logic [AXI_ADDR_W-1:0]   slv_awaddr;
    logic [7:0]              slv_awlen;
    logic [2:0]              slv_awsize;
    logic [1:0]              slv_awburst;
    logic [AXI_ID_W-1:0]     slv_awid;
    logic                    slv_wvalid;
    logic                    slv_wready;
    logic [AXI_DATA_W-1:0]   slv_wdata;
    logic [AXI_DATA_W/8-1:0] slv_wstrb;
    logic                    slv_wlast;
    logic                    slv_bvalid;
    logic                    slv_bready;
    logic [AXI_ID_W-1:0]     slv_bid;
    logic [1:0]              slv_bresp;
    logic                    slv_arvalid;
    logic                    slv_arready;
    logic [AXI_ADDR_W-1:0]   slv_araddr;
    logic [7:0]              slv_arlen;
    logic [2:0]              slv_arsize;
    logic [1:0]              slv_arburst;
    logic [AXI_ID_W-1:0]     slv_arid;
    logic                    slv_rvalid;
    logic                    slv_rready;
    logic [AXI_ID_W-1:0]     slv_rid;
    logic [1:0]              slv_rresp;
    logic [AXI_DATA_W-1:0]   slv_rdata;
    logic                    slv_rlast;

    modport master (
        output slv_awvalid, slv_awaddr, slv_awlen, slv_awsize, slv_awburst, slv_awid,
        output slv_wvalid, slv_wdata, slv_wstrb, slv_wlast, slv_bready,
        output slv_arvalid, slv_araddr, slv_arlen, slv_arsize, slv_arburst, slv_arid, slv_rready,
        input  slv_awready, slv_wready, slv_bvalid, slv_bid, slv_bresp,
        input  slv_arready, slv_rvalid, slv_rid, slv_rresp, slv_rdata, slv_rlast
    );

    modport slave (
        input  slv_awvalid, slv_awaddr, slv_awlen, slv_awsize, slv_awburst, slv_awid,
        input  slv_wvalid, slv_wdata, slv_wstrb, slv_wlast, slv_bready,
        input  slv_arvalid, slv_araddr, slv_arlen, slv_arsize, slv_arburst, slv_arid, slv_rready,
        output slv_awready, slv_wready, slv_bvalid, slv_bid, slv_bresp,
        output slv_arready, slv_rvalid, slv_rid, slv_rresp, slv_rdata, slv_rlast
    );
endinterface

// File: rtl/friscv_axi_ram_slave.sv
// AXI4 RAM responder: in-order reads via an AR FIFO (first R beat 2 cycles after AR), strobed writes, one BRESP per burst.
// arready = FIFO not full; R and B hold until rready/bready. FRISCV_AXI_RAM_DECERR_EN enables out-of-range DECERR.
module friscv_axi_ram_slave #(
    parameter string NAME        = "AXI-RAM-Slave",
    parameter int    AXI_ADDR_W  = 16,
    parameter int    AXI_ID_W    = 8,
    parameter int    AXI_DATA_W  = 128,
    parameter int    OSTDREQ_NUM = 4,
    parameter int    RAM_DEPTH   = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    friscv_axi_ram_slave_if.slave axi
);
    localparam int ADDR_LSB_W = $clog2(AXI_DATA_W / 8);
    localparam int IDX_W      = $clog2(RAM_DEPTH);
    localparam int WA_W       = AXI_ADDR_W - ADDR_LSB_W;
    localparam int STRB_W     = AXI_DATA_W / 8;
    localparam int PTR_W      = $clog2(OSTDREQ_NUM);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(OSTDREQ_NUM);
    localparam string unused_name = NAME;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [WA_W-1:0]     widx;
        logic [7:0]          len;
    } ar_ent_t;

    typedef enum logic       {R_IDLE, R_BURST}         r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;

    logic [AXI_DATA_W-1:0] ram_q [RAM_DEPTH];
    ar_ent_t               fifo_q [OSTDREQ_NUM];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        cnt_q, cnt_d;
    logic                  fifo_full, fifo_empty, push, pop;
    ar_ent_t               ar_ent, fifo_head;

    r_state_t              r_state_q, r_state_d;
    logic [WA_W-1:0]       ridx_q, ridx_d, r_src_idx;
    logic [7:0]            rcnt_q, rcnt_d, r_src_cnt;
    logic                  r_fire;
    logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [AXI_ID_W-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;

    w_state_t              w_state_q, w_state_d;
    logic [WA_W-1:0]       widx_q, widx_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic [AXI_ID_W-1:0]   bid_q, bid_d;
    logic                  slverr_q, slverr_d, decerr_q, decerr_d;
    logic                  ram_we;

    logic                  unused_ok;
    assign unused_ok = ^{axi.slv_awaddr[ADDR_LSB_W-1:0], axi.slv_araddr[ADDR_LSB_W-1:0],
                         axi.slv_awsize, axi.slv_awburst, axi.slv_arsize, axi.slv_arburst};

    // AR request FIFO: registered, so a request is never served in its own handshake cycle
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign push       = axi.slv_arvalid && !fifo_full;
    assign ar_ent     = '{id: axi.slv_arid, widx: axi.slv_araddr[AXI_ADDR_W-1:ADDR_LSB_W], len: axi.slv_arlen};
    assign fifo_head  = fifo_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (push) fifo_q[wr_ptr_q] <= ar_ent;
    end

    // Read engine: the idle state pops and registers beat 0 together, which gives the
    // two-cycle AR-to-R latency and one bubble between consecutive bursts.
    always_comb begin
        r_state_d = r_state_q;
        ridx_d    = ridx_q;
        rcnt_d    = rcnt_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        pop       = 1'b0;
        r_fire    = 1'b0;
        r_src_idx = ridx_q;
        r_src_cnt = rcnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (rvalid_q && axi.slv_rready) rvalid_d = 1'b0;
                if (!rvalid_q && !fifo_empty) begin
                    pop       = 1'b1;
                    r_fire    = 1'b1;
                    r_src_idx = fifo_head.widx;
                    r_src_cnt = fifo_head.len;
                    rid_d     = fifo_head.id;
                end
            end
            R_BURST: r_fire = !rvalid_q || axi.slv_rready;
            default: r_state_d = R_IDLE;
        endcase
        if (r_fire) begin
            rvalid_d  = 1'b1;
            rlast_d   = (r_src_cnt == 8'd0);
            ridx_d    = r_src_idx + 1'b1;
            rcnt_d    = r_src_cnt - 1'b1;
            r_state_d = (r_src_cnt == 8'd0) ? R_IDLE : R_BURST;
`ifdef FRISCV_AXI_RAM_DECERR_EN
            if (r_src_idx >= WA_W'(RAM_DEPTH)) begin
                rdata_d = '0;
                rresp_d = 2'b11;
            end else begin
                rdata_d = ram_q[r_src_idx[IDX_W-1:0]];
                rresp_d = 2'b00;
            end
`else
            rdata_d = ram_q[r_src_idx[IDX_W-1:0]];
            rresp_d = 2'b00;
`endif
        end
    end

    // Write engine: the beat counter, not wlast, ends the burst; a disagreeing wlast only flags SLVERR.
    always_comb begin
        w_state_d = w_state_q;
        widx_d    = widx_q;
        wcnt_d    = wcnt_q;
        bid_d     = bid_q;
        slverr_d  = slverr_q;
        decerr_d  = decerr_q;
        ram_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (axi.slv_awvalid) begin
                    widx_d    = axi.slv_awaddr[AXI_ADDR_W-1:ADDR_LSB_W];
                    wcnt_d    = axi.slv_awlen;
                    bid_d     = axi.slv_awid;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi.slv_wvalid) begin
                    ram_we = 1'b1;
`ifdef FRISCV_AXI_RAM_DECERR_EN
                    if (widx_q >= WA_W'(RAM_DEPTH)) begin
                        ram_we   = 1'b0;
                        decerr_d = 1'b1;
                    end
`endif
                    if (axi.slv_wlast != (wcnt_q == 8'd0)) slverr_d = 1'b1;
                    widx_d = widx_q + 1'b1;
                    wcnt_d = wcnt_q - 1'b1;
                    if (wcnt_q == 8'd0) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.slv_bready) begin
                    slverr_d  = 1'b0;
                    decerr_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (ram_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi.slv_wstrb[b]) ram_q[widx_q[IDX_W-1:0]][8*b +: 8] <= axi.slv_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            r_state_q <= R_IDLE;
            ridx_q    <= '0;
            rcnt_q    <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            w_state_q <= W_IDLE;
            widx_q    <= '0;
            wcnt_q    <= '0;
            bid_q     <= '0;
            slverr_q  <= 1'b0;
            decerr_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            r_state_q <= r_state_d;
            ridx_q    <= ridx_d;
            rcnt_q    <= rcnt_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            w_state_q <= w_state_d;
            widx_q    <= widx_d;
            wcnt_q    <= wcnt_d;
            bid_q     <= bid_d;
            slverr_q  <= slverr_d;
            decerr_q  <= decerr_d;
        end
    end

    assign axi.slv_arready = !fifo_full;
    assign axi.slv_rvalid  = rvalid_q;
    assign axi.slv_rlast   = rlast_q;
    assign axi.slv_rid     = rid_q;
    assign axi.slv_rresp   = rresp_q;
    assign axi.slv_rdata   = rdata_q;
    assign axi.slv_awready = (w_state_q == W_IDLE);
    assign axi.slv_wready  = (w_state_q == W_DATA);
    assign axi.slv_bvalid  = (w_state_q == W_RESP);
    assign axi.slv_bid     = bid_q;
    assign axi.slv_bresp   = decerr_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);
endmodule

// File: tb/tb_friscv_axi_ram_slave.sv
// Directed bench for friscv_axi_ram_slave: each task drives one scenario and checks against hand-computed values.
module tb_friscv_axi_ram_slave;
    localparam int AW = 16, IW = 8, DW = 128, SW = 16, DEPTH = 1024;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    friscv_axi_ram_slave_if #(.AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW)) slv_if ();

    friscv_axi_ram_slave #(
        .NAME("AXI-RAM-Slave"), .AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW),
        .OSTDREQ_NUM(4), .RAM_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .axi(slv_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id, output bit ok);
        slv_if.slv_awaddr = addr; slv_if.slv_awlen = len; slv_if.slv_awid = id;
        slv_if.slv_awsize = 3'd4; slv_if.slv_awburst = 2'b01; slv_if.slv_awvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin ok = slv_if.slv_awready; tick(); end
        slv_if.slv_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] data, input logic [SW-1:0] strb, input logic last, output bit ok);
        slv_if.slv_wdata = data; slv_if.slv_wstrb = strb; slv_if.slv_wlast = last; slv_if.slv_wvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin ok = slv_if.slv_wready; tick(); end
        slv_if.slv_wvalid = 1'b0;
    endtask

    task automatic wait_b(output bit ok, output logic [IW-1:0] id, output logic [1:0] resp);
        slv_if.slv_bready = 1'b1;
        ok = 1'b0; id = '0; resp = '0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (slv_if.slv_bvalid) begin id = slv_if.slv_bid; resp = slv_if.slv_bresp; ok = 1'b1; end
            tick();
        end
        slv_if.slv_bready = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id, output bit ok);
        slv_if.slv_araddr = addr; slv_if.slv_arlen = len; slv_if.slv_arid = id;
        slv_if.slv_arsize = 3'd4; slv_if.slv_arburst = 2'b01; slv_if.slv_arvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin ok = slv_if.slv_arready; tick(); end
        slv_if.slv_arvalid = 1'b0;
    endtask

    task automatic recv_r(output bit ok, output logic [DW-1:0] data, output logic [IW-1:0] id,
                          output logic last, output logic [1:0] resp);
        slv_if.slv_rready = 1'b1;
        ok = 1'b0; data = '0; id = '0; last = 1'b0; resp = '0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (slv_if.slv_rvalid) begin
                data = slv_if.slv_rdata; id = slv_if.slv_rid; last = slv_if.slv_rlast; resp = slv_if.slv_rresp;
                ok = 1'b1;
            end
            tick();
        end
        slv_if.slv_rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        tick(); tick();
        obs = {slv_if.slv_arready, slv_if.slv_awready, slv_if.slv_wready, slv_if.slv_bvalid, slv_if.slv_bid,
               slv_if.slv_bresp, slv_if.slv_rvalid, slv_if.slv_rlast, slv_if.slv_rresp};
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00}) begin
            errors++; $display("FAIL reset_ctrl: got %h exp %h", obs, {1'b1, 1'b1, 16'h0});
        end
        checks++;
        if ({slv_if.slv_rid, slv_if.slv_rdata} !== {8'h00, 128'h0}) begin
            errors++; $display("FAIL reset_rid_rdata: got %h %h exp 0 0", slv_if.slv_rid, slv_if.slv_rdata);
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_single_write_read();
        bit ok; logic [IW-1:0] id; logic [1:0] resp;
        send_aw(16'h0040, 8'd0, 8'h3C, ok);
        checks++;
        if ({ok, slv_if.slv_wready} !== 2'b11) begin
            errors++; $display("FAIL single_wready_t1: got %b exp 11", {ok, slv_if.slv_wready});
        end
        send_w({16{8'hA5}}, 16'hFFFF, 1'b1, ok);
        checks++;
        if ({ok, slv_if.slv_bvalid} !== 2'b11) begin
            errors++; $display("FAIL single_bvalid_next: got %b exp 11", {ok, slv_if.slv_bvalid});
        end
        wait_b(ok, id, resp);
        checks++;
        if ({ok, id, resp} !== {1'b1, 8'h3C, 2'b00}) begin
            errors++; $display("FAIL single_bresp: got ok=%b id=%h resp=%b exp 1 3c 00", ok, id, resp);
        end
        slv_if.slv_rready = 1'b0;
        send_ar(16'h0040, 8'd0, 8'h11, ok);
        checks++;
        if ({ok, slv_if.slv_rvalid} !== 2'b10) begin
            errors++; $display("FAIL read_no_rvalid_t1: got %b exp 10", {ok, slv_if.slv_rvalid});
        end
        tick();
        checks++;
        if ({slv_if.slv_rvalid, slv_if.slv_rlast, slv_if.slv_rid, slv_if.slv_rresp} !== {1'b1, 1'b1, 8'h11, 2'b00}) begin
            errors++; $display("FAIL read_t2_ctrl: got %b %b %h %b exp 1 1 11 00", slv_if.slv_rvalid,
                               slv_if.slv_rlast, slv_if.slv_rid, slv_if.slv_rresp);
        end
        checks++;
        if (slv_if.slv_rdata !== {16{8'hA5}}) begin
            errors++; $display("FAIL read_t2_data: got %h exp %h", slv_if.slv_rdata, {16{8'hA5}});
        end
        slv_if.slv_rready = 1'b1;
        tick();
        slv_if.slv_rready = 1'b0;
        checks++;
        if (slv_if.slv_rvalid !== 1'b0) begin
            errors++; $display("FAIL read_done: got rvalid=%b exp 0", slv_if.slv_rvalid);
        end
    endtask

    task automatic test_partial_strobe();
        bit ok, ok_all; logic [IW-1:0] id; logic [1:0] resp; logic [DW-1:0] d; logic last;
        ok_all = 1'b1;
        send_aw(16'h0080, 8'd0, 8'h01, ok); ok_all &= ok;
        send_w({16{8'hFF}}, 16'hFFFF, 1'b1, ok); ok_all &= ok;
        wait_b(ok, id, resp); ok_all &= ok;
        send_aw(16'h0080, 8'd0, 8'h02, ok); ok_all &= ok;
        send_w(128'h0, 16'h000F, 1'b1, ok); ok_all &= ok;
        wait_b(ok, id, resp); ok_all &= ok;
        checks++;
        if ({ok_all, id, resp} !== {1'b1, 8'h02, 2'b00}) begin
            errors++; $display("FAIL strobe_bresp: got ok=%b id=%h resp=%b exp 1 02 00", ok_all, id, resp);
        end
        send_ar(16'h0080, 8'd0, 8'h12, ok);
        recv_r(ok, d, id, last, resp);
        checks++;
        if ({ok, d} !== {1'b1, {12{8'hFF}}, 32'h0}) begin
            errors++; $display("FAIL strobe_data: got ok=%b %h exp %h", ok, d, {{12{8'hFF}}, 32'h0});
        end
    endtask

    task automatic test_burst_write();
        bit ok, ok_all; logic [IW-1:0] id; logic [1:0] resp;
        ok_all = 1'b1;
        send_aw(16'h0000, 8'd3, 8'h05, ok); ok_all &= ok;
        for (int k = 0; k < 4; k++) begin
            send_w({16{8'(8'h10 + k)}}, 16'hFFFF, (k == 3), ok); ok_all &= ok;
        end
        wait_b(ok, id, resp); ok_all &= ok;
        checks++;
        if ({ok_all, id, resp} !== {1'b1, 8'h05, 2'b00}) begin
            errors++; $display("FAIL burst_write_bresp: got ok=%b id=%h resp=%b exp 1 05 00", ok_all, id, resp);
        end
    endtask

    task automatic test_burst_read_stall();
        bit ok; int beat; bit have_prev; logic [DW-1:0] prev;
        slv_if.slv_rready = 1'b0;
        send_ar(16'h0000, 8'd3, 8'h21, ok);
        beat = 0; have_prev = 1'b0; prev = '0;
        for (int c = 0; c < 40 && beat < 4; c++) begin
            slv_if.slv_rready = c[0];
            if (slv_if.slv_rvalid) begin
                if (have_prev) begin
                    checks++;
                    if (slv_if.slv_rdata !== prev) begin
                        errors++; $display("FAIL burst_stall_stable: got %h exp %h", slv_if.slv_rdata, prev);
                    end
                end
                if (slv_if.slv_rready) begin
                    checks++;
                    if ({slv_if.slv_rdata, slv_if.slv_rlast, slv_if.slv_rid} !== {{16{8'(8'h10 + beat)}}, (beat == 3), 8'h21}) begin
                        errors++; $display("FAIL burst_beat%0d: got %h last=%b id=%h", beat, slv_if.slv_rdata,
                                           slv_if.slv_rlast, slv_if.slv_rid);
                    end
                    beat++; have_prev = 1'b0;
                end else begin
                    prev = slv_if.slv_rdata; have_prev = 1'b1;
                end
            end
            tick();
        end
        slv_if.slv_rready = 1'b0;
        checks++;
        if ({ok, beat} !== {1'b1, 32'd4}) begin
            errors++; $display("FAIL burst_beats: got ok=%b beats=%0d exp 1 4", ok, beat);
        end
    endtask

    task automatic test_outstanding();
        bit ok, ok_all; logic [DW-1:0] d, e; logic [IW-1:0] id; logic last; logic [1:0] resp;
        slv_if.slv_rready = 1'b0;
        ok_all = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_ar(AW'(k * 16), 8'd0, 8'(8'h20 + k), ok); ok_all &= ok;
        end
        checks++;
        if ({ok_all, slv_if.slv_arready} !== 2'b10) begin
            errors++; $display("FAIL ostd_full: got ok=%b arready=%b exp 1 0", ok_all, slv_if.slv_arready);
        end
        tick(); tick();
        checks++;
        if (slv_if.slv_arready !== 1'b0) begin
            errors++; $display("FAIL ostd_full_hold: got arready=%b exp 0", slv_if.slv_arready);
        end
        for (int k = 0; k < 5; k++) begin
            e = (k == 4) ? {16{8'hA5}} : {16{8'(8'h10 + k)}};
            recv_r(ok, d, id, last, resp);
            checks++;
            if ({ok, id, d, last} !== {1'b1, 8'(8'h20 + k), e, 1'b1}) begin
                errors++; $display("FAIL ostd_resp%0d: got ok=%b id=%h data=%h last=%b exp id=%h data=%h",
                                   k, ok, id, d, last, 8'(8'h20 + k), e);
            end
        end
        checks++;
        if (slv_if.slv_arready !== 1'b1) begin
            errors++; $display("FAIL ostd_drained: got arready=%b exp 1", slv_if.slv_arready);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [3:0] pat; logic [DW-1:0] got [2]; logic [IW-1:0] gid [2]; int nb;
        slv_if.slv_rready = 1'b1;
        nb = 0; pat = '0; got[0] = '0; got[1] = '0; gid[0] = '0; gid[1] = '0;
        slv_if.slv_arsize = 3'd4; slv_if.slv_arburst = 2'b01; slv_if.slv_arlen = 8'd0;
        slv_if.slv_araddr = 16'h0040; slv_if.slv_arid = 8'h31; slv_if.slv_arvalid = 1'b1;
        ok = slv_if.slv_arready;
        tick();
        slv_if.slv_araddr = 16'h0080; slv_if.slv_arid = 8'h32;
        pat[0] = slv_if.slv_rvalid; ok &= slv_if.slv_arready;
        tick();
        slv_if.slv_arvalid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            pat[i] = slv_if.slv_rvalid;
            if (slv_if.slv_rvalid && nb < 2) begin got[nb] = slv_if.slv_rdata; gid[nb] = slv_if.slv_rid; nb++; end
            tick();
        end
        slv_if.slv_rready = 1'b0;
        checks++;
        if ({ok, pat} !== {1'b1, 4'b1010}) begin
            errors++; $display("FAIL b2b_bubble: got ok=%b rvalid pattern=%b exp 1 1010", ok, pat);
        end
        checks++;
        if ({gid[0], got[0], gid[1], got[1]} !== {8'h31, {16{8'hA5}}, 8'h32, {12{8'hFF}}, 32'h0}) begin
            errors++; $display("FAIL b2b_data: got %h %h / %h %h", gid[0], got[0], gid[1], got[1]);
        end
    endtask

    task automatic test_wlast_err();
        bit ok; logic [IW-1:0] id; logic [1:0] resp;
        send_aw(16'h0100, 8'd1, 8'h07, ok);
        send_w({16{8'h33}}, 16'hFFFF, 1'b1, ok);
        checks++;
        if ({ok, slv_if.slv_bvalid, slv_if.slv_wready} !== 3'b101) begin
            errors++; $display("FAIL err_burst_continues: got %b exp 101", {ok, slv_if.slv_bvalid, slv_if.slv_wready});
        end
        send_w({16{8'h44}}, 16'hFFFF, 1'b0, ok);
        wait_b(ok, id, resp);
        checks++;
        if ({ok, id, resp} !== {1'b1, 8'h07, 2'b10}) begin
            errors++; $display("FAIL err_slverr: got ok=%b id=%h resp=%b exp 1 07 10", ok, id, resp);
        end
        send_aw(16'h0120, 8'd0, 8'h08, ok);
        send_w({16{8'h55}}, 16'hFFFF, 1'b1, ok);
        wait_b(ok, id, resp);
        checks++;
        if ({ok, id, resp} !== {1'b1, 8'h08, 2'b00}) begin
            errors++; $display("FAIL err_cleared: got ok=%b id=%h resp=%b exp 1 08 00", ok, id, resp);
        end
    endtask

    task automatic test_wrap_decerr();
        bit ok; logic [DW-1:0] d, e; logic [IW-1:0] id; logic last; logic [1:0] resp, er;
`ifdef FRISCV_AXI_RAM_DECERR_EN
        e = '0; er = 2'b11;
`else
        e = {16{8'h10}}; er = 2'b00;
`endif
        send_ar(AW'(DEPTH * 16), 8'd0, 8'h41, ok);
        recv_r(ok, d, id, last, resp);
        checks++;
        if ({ok, id, d, resp} !== {1'b1, 8'h41, e, er}) begin
            errors++; $display("FAIL wrap_index: got ok=%b id=%h data=%h resp=%b exp data=%h resp=%b", ok, id, d, resp, e, er);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; bit any_resp;
        send_aw(16'h0200, 8'd3, 8'h09, ok);
        send_w({16{8'h77}}, 16'hFFFF, 1'b0, ok);
        slv_if.slv_rready = 1'b0;
        send_ar(16'h0000, 8'd3, 8'h50, ok);
        tick();
        areset = 1'b1;
        #1;
        checks++;
        if ({slv_if.slv_awready, slv_if.slv_wready, slv_if.slv_bvalid, slv_if.slv_arready, slv_if.slv_rvalid} !== 5'b10010) begin
            errors++; $display("FAIL midreset_idle: got %b exp 10010", {slv_if.slv_awready, slv_if.slv_wready,
                               slv_if.slv_bvalid, slv_if.slv_arready, slv_if.slv_rvalid});
        end
        tick();
        areset = 1'b0;
        slv_if.slv_rready = 1'b1; slv_if.slv_bready = 1'b1;
        any_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            any_resp |= slv_if.slv_rvalid | slv_if.slv_bvalid;
            tick();
        end
        slv_if.slv_rready = 1'b0; slv_if.slv_bready = 1'b0;
        checks++;
        if (any_resp !== 1'b0) begin
            errors++; $display("FAIL midreset_dropped: got response=%b exp 0", any_resp);
        end
    endtask

    initial begin
        slv_if.slv_awvalid = 1'b0; slv_if.slv_awaddr = '0; slv_if.slv_awlen = '0; slv_if.slv_awsize = '0;
        slv_if.slv_awburst = '0; slv_if.slv_awid = '0;
        slv_if.slv_wvalid = 1'b0; slv_if.slv_wdata = '0; slv_if.slv_wstrb = '0; slv_if.slv_wlast = 1'b0;
        slv_if.slv_bready = 1'b0;
        slv_if.slv_arvalid = 1'b0; slv_if.slv_araddr = '0; slv_if.slv_arlen = '0; slv_if.slv_arsize = '0;
        slv_if.slv_arburst = '0; slv_if.slv_arid = '0;
        slv_if.slv_rready = 1'b0;
        test_reset();
        test_single_write_read();
        test_partial_strobe();
        test_burst_write();
        test_burst_read_stall();
        test_outstanding();
        test_back_to_back();
        test_wlast_err();
        test_wrap_decerr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
        $fatal(1, "watchdog expired");
    end
endmodule
